// File: rtl/core_pkg.sv
// Core-wide types and constants shared by the integer pipeline stages.
package core_pkg;

    localparam int unsigned XLEN = 32;

    // ALU operation codes as carried down the pipeline.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SLL  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_SRA  = 4'd6,
        ALU_OR   = 4'd7,
        ALU_AND  = 4'd8,
        ALU_SUB  = 4'd9
    } alu_op_e;

    // Operand source selects.
    localparam logic SEL_A_RS1 = 1'b0;
    localparam logic SEL_A_PC  = 1'b1;
    localparam logic SEL_B_RS2 = 1'b0;
    localparam logic SEL_B_IMM = 1'b1;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Bundle of decode, forwarding, control and EX-output signals of the operand stage.
interface ex_operand_stage_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
);
    logic               id_valid;
    logic [XLEN-1:0]    id_pc;
    logic [XLEN-1:0]    id_rs1_data;
    logic [XLEN-1:0]    id_rs2_data;
    logic [RADDR_W-1:0] id_rs1_addr;
    logic [RADDR_W-1:0] id_rs2_addr;
    logic [RADDR_W-1:0] id_rd_addr;
    logic [XLEN-1:0]    id_imm;
    logic [3:0]         id_alu_op;
    logic               id_sel_a;
    logic               id_sel_b;
    logic               id_reg_wr;
    logic               id_mem_rd;
    logic               id_mem_wr;
    logic               mem_reg_wr;
    logic [RADDR_W-1:0] mem_rd_addr;
    logic [XLEN-1:0]    mem_result;
    logic               wb_reg_wr;
    logic [RADDR_W-1:0] wb_rd_addr;
    logic [XLEN-1:0]    wb_result;
    logic               stall_in;
    logic               flush;
    logic               id_stall;
    logic               ex_valid;
    logic [XLEN-1:0]    alu_a;
    logic [XLEN-1:0]    alu_b;
    logic [3:0]         alu_op;
    logic [XLEN-1:0]    ex_store_data;
    logic [RADDR_W-1:0] ex_rd_addr;
    logic               ex_reg_wr;
    logic               ex_mem_rd;
    logic               ex_mem_wr;
    logic [31:0]        bubble_count;

    // Upstream/pipeline side driving the stage.
    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_rs1_addr, id_rs2_addr,
               id_rd_addr, id_imm, id_alu_op, id_sel_a, id_sel_b, id_reg_wr, id_mem_rd,
               id_mem_wr, mem_reg_wr, mem_rd_addr, mem_result, wb_reg_wr, wb_rd_addr,
               wb_result, stall_in, flush,
        input  id_stall, ex_valid, alu_a, alu_b, alu_op, ex_store_data, ex_rd_addr,
               ex_reg_wr, ex_mem_rd, ex_mem_wr, bubble_count
    );

    // The operand stage itself.
    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_rs1_addr, id_rs2_addr,
               id_rd_addr, id_imm, id_alu_op, id_sel_a, id_sel_b, id_reg_wr, id_mem_rd,
               id_mem_wr, mem_reg_wr, mem_rd_addr, mem_result, wb_reg_wr, wb_rd_addr,
               wb_result, stall_in, flush,
        output id_stall, ex_valid, alu_a, alu_b, alu_op, ex_store_data, ex_rd_addr,
               ex_reg_wr, ex_mem_rd, ex_mem_wr, bubble_count
    );

endinterface

// File: rtl/fwd_mux.sv
// Forwarding select for one register operand: MEM result, else WB result, else held data.
module fwd_mux #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] i_rs_addr,
    input  logic [XLEN-1:0]    i_rs_data,
    input  logic               i_mem_reg_wr,
    input  logic [RADDR_W-1:0] i_mem_rd_addr,
    input  logic [XLEN-1:0]    i_mem_result,
    input  logic               i_wb_reg_wr,
    input  logic [RADDR_W-1:0] i_wb_rd_addr,
    input  logic [XLEN-1:0]    i_wb_result,
    output logic [XLEN-1:0]    o_data
);
    logic w_mem_hit;
    logic w_wb_hit;

    // x0 is hardwired zero, so a write to it is never a producer.
    assign w_mem_hit = i_mem_reg_wr && (i_mem_rd_addr != '0) && (i_mem_rd_addr == i_rs_addr);
    assign w_wb_hit  = i_wb_reg_wr && (i_wb_rd_addr != '0) && (i_wb_rd_addr == i_rs_addr);

    // MEM holds the younger producer, so it wins over WB.
    always_comb begin
        o_data = i_rs_data;
        if (w_mem_hit) begin
            o_data = i_mem_result;
        end else if (w_wb_hit) begin
            o_data = i_wb_result;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with operand forwarding, load-use bubble insertion and bubble counting.
module ex_operand_stage #(
    parameter int unsigned XLEN    = core_pkg::XLEN,
    parameter int unsigned RADDR_W = 5
) (
    input logic               clk,
    input logic               rst_n,
    ex_operand_stage_if.slave bus
);
    import core_pkg::*;

    logic               r_valid;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_rs1_data;
    logic [XLEN-1:0]    r_rs2_data;
    logic [XLEN-1:0]    r_imm;
    logic [RADDR_W-1:0] r_rs1_addr;
    logic [RADDR_W-1:0] r_rs2_addr;
    logic [RADDR_W-1:0] r_rd_addr;
    alu_op_e            r_alu_op;
    logic               r_sel_a;
    logic               r_sel_b;
    logic               r_reg_wr;
    logic               r_mem_rd;
    logic               r_mem_wr;
    logic [31:0]        r_bubble_count;

    logic               w_load_use;
    logic               w_wb_hit_rs1;
    logic               w_wb_hit_rs2;
    logic [XLEN-1:0]    w_fwd_rs1;
    logic [XLEN-1:0]    w_fwd_rs2;

    // Hazard and hold-refresh detection; store data counts as an rs2 use.
    always_comb begin
        w_load_use = r_valid && r_mem_rd && (r_rd_addr != '0) && bus.id_valid &&
                     (((bus.id_sel_a == SEL_A_RS1) && (bus.id_rs1_addr == r_rd_addr)) ||
                      (((bus.id_sel_b == SEL_B_RS2) || bus.id_mem_wr) &&
                       (bus.id_rs2_addr == r_rd_addr)));
        w_wb_hit_rs1 = bus.wb_reg_wr && (bus.wb_rd_addr != '0) &&
                       (bus.wb_rd_addr == r_rs1_addr);
        w_wb_hit_rs2 = bus.wb_reg_wr && (bus.wb_rd_addr != '0) &&
                       (bus.wb_rd_addr == r_rs2_addr);
    end

    // EX register update: flush, then downstream hold, then bubble, then normal load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd_addr  <= '0;
            r_alu_op   <= ALU_ADD;
            r_sel_a    <= SEL_A_RS1;
            r_sel_b    <= SEL_B_RS2;
            r_reg_wr   <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
        end else if (bus.flush) begin
            r_valid  <= 1'b0;
            r_reg_wr <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_alu_op <= ALU_ADD;
        end else if (bus.stall_in) begin
            // A value retiring from WB during the hold would otherwise be lost.
            if (w_wb_hit_rs1) begin
                r_rs1_data <= bus.wb_result;
            end
            if (w_wb_hit_rs2) begin
                r_rs2_data <= bus.wb_result;
            end
        end else if (w_load_use) begin
            r_valid  <= 1'b0;
            r_reg_wr <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_alu_op <= ALU_ADD;
        end else begin
            r_valid    <= bus.id_valid;
            r_pc       <= bus.id_pc;
            r_rs1_data <= bus.id_rs1_data;
            r_rs2_data <= bus.id_rs2_data;
            r_imm      <= bus.id_imm;
            r_rs1_addr <= bus.id_rs1_addr;
            r_rs2_addr <= bus.id_rs2_addr;
            r_rd_addr  <= bus.id_rd_addr;
            r_alu_op   <= alu_op_e'(bus.id_alu_op);
            r_sel_a    <= bus.id_sel_a;
            r_sel_b    <= bus.id_sel_b;
            r_reg_wr   <= bus.id_reg_wr;
            r_mem_rd   <= bus.id_mem_rd;
            r_mem_wr   <= bus.id_mem_wr;
        end
    end

    // Count only bubbles actually inserted; saturate instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_count <= '0;
        end else if (!bus.flush && !bus.stall_in && w_load_use && (r_bubble_count != '1)) begin
            r_bubble_count <= r_bubble_count + 32'd1;
        end
    end

    fwd_mux #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W)
    ) u_fwd_rs1 (
        .i_rs_addr     (r_rs1_addr),
        .i_rs_data     (r_rs1_data),
        .i_mem_reg_wr  (bus.mem_reg_wr),
        .i_mem_rd_addr (bus.mem_rd_addr),
        .i_mem_result  (bus.mem_result),
        .i_wb_reg_wr   (bus.wb_reg_wr),
        .i_wb_rd_addr  (bus.wb_rd_addr),
        .i_wb_result   (bus.wb_result),
        .o_data        (w_fwd_rs1)
    );

    fwd_mux #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W)
    ) u_fwd_rs2 (
        .i_rs_addr     (r_rs2_addr),
        .i_rs_data     (r_rs2_data),
        .i_mem_reg_wr  (bus.mem_reg_wr),
        .i_mem_rd_addr (bus.mem_rd_addr),
        .i_mem_result  (bus.mem_result),
        .i_wb_reg_wr   (bus.wb_reg_wr),
        .i_wb_rd_addr  (bus.wb_rd_addr),
        .i_wb_result   (bus.wb_result),
        .o_data        (w_fwd_rs2)
    );

    assign bus.id_stall      = w_load_use || bus.stall_in;
    assign bus.ex_valid      = r_valid;
    assign bus.alu_a         = (r_sel_a == SEL_A_PC)  ? r_pc  : w_fwd_rs1;
    assign bus.alu_b         = (r_sel_b == SEL_B_IMM) ? r_imm : w_fwd_rs2;
    assign bus.alu_op        = r_alu_op;
    assign bus.ex_store_data = w_fwd_rs2;
    assign bus.ex_rd_addr    = r_rd_addr;
    assign bus.ex_reg_wr     = r_reg_wr && r_valid;
    assign bus.ex_mem_rd     = r_mem_rd && r_valid;
    assign bus.ex_mem_wr     = r_mem_wr && r_valid;
    assign bus.bubble_count  = r_bubble_count;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios plus randomized traffic against a reference model.
module tb_ex_operand_stage;

    logic clk;
    logic rst_n;

    ex_operand_stage_if bus_if ();

    ex_operand_stage u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the instruction sitting in EX; known = fields are defined, op_zero = op known 0.
    typedef struct packed {
        logic        valid;
        logic        known;
        logic        op_zero;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        sa;
        logic        sb;
        logic        rw;
        logic        mr;
        logic        mw;
    } ex_t;

    ex_t         m;
    logic [31:0] m_cnt;
    int          n_pass;
    int          n_total;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Value of architectural register r as the EX instruction should see it now.
    function automatic logic [31:0] seen(input logic [4:0] r, input logic [31:0] held);
        if (r == 5'd0) return held;
        if (bus_if.mem_reg_wr && bus_if.mem_rd_addr == r) return bus_if.mem_result;
        if (bus_if.wb_reg_wr && bus_if.wb_rd_addr == r) return bus_if.wb_result;
        return held;
    endfunction

    // True when the ID instruction needs the result of the load currently in EX.
    function automatic logic load_use();
        logic uses_rs1;
        logic uses_rs2;
        uses_rs1 = !bus_if.id_sel_a && (bus_if.id_rs1_addr == m.rd);
        uses_rs2 = (!bus_if.id_sel_b || bus_if.id_mem_wr) && (bus_if.id_rs2_addr == m.rd);
        return m.valid && m.mr && (m.rd != 5'd0) && bus_if.id_valid && (uses_rs1 || uses_rs2);
    endfunction

    task automatic model_reset();
        m         = '0;
        m.known   = 1'b1;
        m.op_zero = 1'b1;
        m_cnt     = 32'd0;
    endtask

    task automatic clear_inputs();
        bus_if.id_valid    = 1'b0;
        bus_if.id_pc       = 32'd0;
        bus_if.id_rs1_data = 32'd0;
        bus_if.id_rs2_data = 32'd0;
        bus_if.id_rs1_addr = 5'd0;
        bus_if.id_rs2_addr = 5'd0;
        bus_if.id_rd_addr  = 5'd0;
        bus_if.id_imm      = 32'd0;
        bus_if.id_alu_op   = 4'd0;
        bus_if.id_sel_a    = 1'b0;
        bus_if.id_sel_b    = 1'b0;
        bus_if.id_reg_wr   = 1'b0;
        bus_if.id_mem_rd   = 1'b0;
        bus_if.id_mem_wr   = 1'b0;
        bus_if.mem_reg_wr  = 1'b0;
        bus_if.mem_rd_addr = 5'd0;
        bus_if.mem_result  = 32'd0;
        bus_if.wb_reg_wr   = 1'b0;
        bus_if.wb_rd_addr  = 5'd0;
        bus_if.wb_result   = 32'd0;
        bus_if.stall_in    = 1'b0;
        bus_if.flush       = 1'b0;
    endtask

    task automatic set_id(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic mr);
        bus_if.id_valid    = 1'b1;
        bus_if.id_pc       = 32'h0000_0400;
        bus_if.id_rs1_addr = a1;
        bus_if.id_rs2_addr = a2;
        bus_if.id_rd_addr  = rd;
        bus_if.id_rs1_data = d1;
        bus_if.id_rs2_data = d2;
        bus_if.id_imm      = 32'h0000_0100;
        bus_if.id_alu_op   = 4'd0;
        bus_if.id_sel_a    = 1'b0;
        bus_if.id_sel_b    = mr;
        bus_if.id_reg_wr   = 1'b1;
        bus_if.id_mem_rd   = mr;
        bus_if.id_mem_wr   = 1'b0;
    endtask

    task automatic randomize_inputs();
        bus_if.id_valid    = ($urandom_range(0, 9) != 0);
        bus_if.id_pc       = $urandom;
        bus_if.id_rs1_data = $urandom;
        bus_if.id_rs2_data = $urandom;
        bus_if.id_rs1_addr = 5'($urandom_range(0, 7));
        bus_if.id_rs2_addr = 5'($urandom_range(0, 7));
        bus_if.id_rd_addr  = 5'($urandom_range(0, 7));
        bus_if.id_imm      = $urandom;
        bus_if.id_alu_op   = 4'($urandom_range(0, 9));
        bus_if.id_sel_a    = ($urandom_range(0, 3) == 0);
        bus_if.id_sel_b    = ($urandom_range(0, 3) == 0);
        bus_if.id_mem_rd   = ($urandom_range(0, 2) == 0);
        bus_if.id_mem_wr   = !bus_if.id_mem_rd && ($urandom_range(0, 3) == 0);
        bus_if.id_reg_wr   = !bus_if.id_mem_wr;
        bus_if.mem_reg_wr  = ($urandom_range(0, 1) == 0);
        bus_if.mem_rd_addr = 5'($urandom_range(0, 7));
        bus_if.mem_result  = $urandom;
        bus_if.wb_reg_wr   = ($urandom_range(0, 1) == 0);
        bus_if.wb_rd_addr  = 5'($urandom_range(0, 7));
        bus_if.wb_result   = $urandom;
        bus_if.stall_in    = ($urandom_range(0, 5) == 0);
        bus_if.flush       = ($urandom_range(0, 9) == 0);
    endtask

    // Compare every output against the model, 1 time unit after inputs change.
    task automatic settle();
        logic [31:0] f1;
        logic [31:0] f2;
        #1;
        f1 = seen(m.a1, m.rs1);
        f2 = seen(m.a2, m.rs2);
        check("id_stall", 32'(bus_if.id_stall), 32'(load_use() || bus_if.stall_in));
        check("ex_valid", 32'(bus_if.ex_valid), 32'(m.valid));
        check("ex_reg_wr", 32'(bus_if.ex_reg_wr), 32'(m.valid && m.rw));
        check("ex_mem_rd", 32'(bus_if.ex_mem_rd), 32'(m.valid && m.mr));
        check("ex_mem_wr", 32'(bus_if.ex_mem_wr), 32'(m.valid && m.mw));
        check("bubble_count", bus_if.bubble_count, m_cnt);
        if (m.known) begin
            check("alu_a", bus_if.alu_a, m.sa ? m.pc : f1);
            check("alu_b", bus_if.alu_b, m.sb ? m.imm : f2);
            check("ex_store_data", bus_if.ex_store_data, f2);
            check("ex_rd_addr", 32'(bus_if.ex_rd_addr), 32'(m.rd));
        end
        if (m.known || m.op_zero) begin
            check("alu_op", 32'(bus_if.alu_op), 32'(m.op));
        end
    endtask

    // Apply the EX update rules to the model across one rising edge.
    task automatic advance();
        ex_t         n;
        logic [31:0] n_cnt;
        logic        hz;
        hz    = load_use();
        n     = m;
        n_cnt = m_cnt;
        if (bus_if.flush) begin
            n.valid   = 1'b0;
            n.rw      = 1'b0;
            n.mr      = 1'b0;
            n.mw      = 1'b0;
            n.known   = 1'b0;
            n.op_zero = 1'b0;
        end else if (bus_if.stall_in) begin
            if (bus_if.wb_reg_wr && bus_if.wb_rd_addr != 5'd0 && bus_if.wb_rd_addr == m.a1)
                n.rs1 = bus_if.wb_result;
            if (bus_if.wb_reg_wr && bus_if.wb_rd_addr != 5'd0 && bus_if.wb_rd_addr == m.a2)
                n.rs2 = bus_if.wb_result;
        end else if (hz) begin
            n.valid   = 1'b0;
            n.rw      = 1'b0;
            n.mr      = 1'b0;
            n.mw      = 1'b0;
            n.known   = 1'b0;
            n.op_zero = 1'b1;
            n.op      = 4'd0;
            n_cnt     = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 32'd1;
        end else begin
            n.valid   = bus_if.id_valid;
            n.known   = 1'b1;
            n.op_zero = 1'b0;
            n.pc      = bus_if.id_pc;
            n.rs1     = bus_if.id_rs1_data;
            n.rs2     = bus_if.id_rs2_data;
            n.imm     = bus_if.id_imm;
            n.a1      = bus_if.id_rs1_addr;
            n.a2      = bus_if.id_rs2_addr;
            n.rd      = bus_if.id_rd_addr;
            n.op      = bus_if.id_alu_op;
            n.sa      = bus_if.id_sel_a;
            n.sb      = bus_if.id_sel_b;
            n.rw      = bus_if.id_reg_wr;
            n.mr      = bus_if.id_mem_rd;
            n.mw      = bus_if.id_mem_wr;
        end
        @(posedge clk);
        m     = n;
        m_cnt = n_cnt;
        @(negedge clk);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        settle();
        check("rst_alu_a", bus_if.alu_a, 32'd0);
        advance();

        // Back-to-back dependent ADDs: x3 forwarded from MEM.
        clear_inputs(); set_id(5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 1'b0); settle(); advance();
        clear_inputs(); set_id(5'd3, 5'd1, 5'd4, 32'd0, 32'd10, 1'b0); settle();
        check("t1_first_a", bus_if.alu_a, 32'd10);
        advance();
        clear_inputs();
        bus_if.mem_reg_wr = 1'b1; bus_if.mem_rd_addr = 5'd3; bus_if.mem_result = 32'd30;
        settle();
        check("t1_fwd_mem", bus_if.alu_a, 32'd30);
        check("t1_no_stall", 32'(bus_if.id_stall), 32'd0);
        advance();

        // MEM and WB both write x5: MEM wins.
        clear_inputs(); set_id(5'd5, 5'd0, 5'd9, 32'h5, 32'd0, 1'b0); settle(); advance();
        clear_inputs();
        bus_if.mem_reg_wr = 1'b1; bus_if.mem_rd_addr = 5'd5; bus_if.mem_result = 32'h11;
        bus_if.wb_reg_wr  = 1'b1; bus_if.wb_rd_addr  = 5'd5; bus_if.wb_result  = 32'h22;
        settle();
        check("t2_mem_over_wb", bus_if.alu_a, 32'h11);
        advance();

        // LW x6 then ADD x7 = x6 + x1: one bubble.
        clear_inputs(); set_id(5'd1, 5'd0, 5'd6, 32'h1000, 32'd0, 1'b1); settle(); advance();
        clear_inputs(); set_id(5'd6, 5'd1, 5'd7, 32'd0, 32'h7, 1'b0); settle();
        check("t3_stall", 32'(bus_if.id_stall), 32'd1);
        advance();
        settle();
        check("t3_bubble_valid", 32'(bus_if.ex_valid), 32'd0);
        check("t3_count", bus_if.bubble_count, 32'd1);
        check("t3_stall_gone", 32'(bus_if.id_stall), 32'd0);
        advance();
        bus_if.wb_reg_wr = 1'b1; bus_if.wb_rd_addr = 5'd6; bus_if.wb_result = 32'h66;
        settle();
        check("t3_add_enters", 32'(bus_if.ex_valid), 32'd1);
        check("t3_fwd_load", bus_if.alu_a, 32'h66);
        advance();

        // x0 is never forwarded.
        clear_inputs(); set_id(5'd0, 5'd0, 5'd10, 32'd0, 32'd0, 1'b0); settle(); advance();
        clear_inputs();
        bus_if.mem_reg_wr = 1'b1; bus_if.mem_rd_addr = 5'd0; bus_if.mem_result = 32'hDEAD;
        settle();
        check("t4_x0", bus_if.alu_a, 32'd0);
        advance();

        // Three-cycle hold while WB retires x8 into the held rs2.
        clear_inputs(); set_id(5'd1, 5'd8, 5'd11, 32'h3, 32'h99, 1'b0); settle(); advance();
        clear_inputs(); set_id(5'd2, 5'd3, 5'd12, 32'hAA, 32'hBB, 1'b0);
        bus_if.stall_in = 1'b1;
        bus_if.wb_reg_wr = 1'b1; bus_if.wb_rd_addr = 5'd8; bus_if.wb_result = 32'h55;
        settle();
        check("t5_stall", 32'(bus_if.id_stall), 32'd1);
        advance();
        bus_if.wb_reg_wr = 1'b0;
        settle(); advance();
        settle(); advance();
        clear_inputs(); settle();
        check("t5_alu_b", bus_if.alu_b, 32'h55);
        check("t5_alu_a", bus_if.alu_a, 32'h3);
        check("t5_rd", 32'(bus_if.ex_rd_addr), 32'd11);
        advance();

        // Flush, stall_in and load-use together.
        clear_inputs(); set_id(5'd1, 5'd0, 5'd6, 32'h1000, 32'd0, 1'b1); settle(); advance();
        clear_inputs(); set_id(5'd6, 5'd1, 5'd7, 32'd0, 32'h7, 1'b0);
        bus_if.stall_in = 1'b1; bus_if.flush = 1'b1;
        settle();
        check("t6_stall", 32'(bus_if.id_stall), 32'd1);
        advance();
        clear_inputs(); settle();
        check("t6_flushed", 32'(bus_if.ex_valid), 32'd0);
        check("t6_count", bus_if.bubble_count, 32'd1);
        advance();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            settle();
            advance();
        end

        // Asynchronous reset mid-run clears everything at once.
        randomize_inputs();
        rst_n = 1'b0;
        model_reset();
        settle();
        check("rst_bubble", bus_if.bubble_count, 32'd0);
        check("rst_alu_b", bus_if.alu_b, 32'd0);
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        settle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
